// File: rtl/scmp_uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : scmp_uart_pkg
// Description : Shared definitions for the SC/MP bus UART. Holds the register
//               offsets, the STATUS and CTRL bit positions, and the state
//               encoding used by both the TX and RX state machines.
// Revision    : 1.0  initial release
// ============================================================================
package scmp_uart_pkg;

    // Register offsets within the 4-byte window (addr[1:0])
    localparam logic [1:0] c_REG_DATA   = 2'd0;
    localparam logic [1:0] c_REG_STATUS = 2'd1;
    localparam logic [1:0] c_REG_CTRL   = 2'd2;
    localparam logic [1:0] c_REG_NONE   = 2'd3;

    // STATUS bit positions
    localparam int c_ST_RX_VALID  = 0;
    localparam int c_ST_TX_BUSY   = 1;
    localparam int c_ST_OVERRUN   = 2;
    localparam int c_ST_FRAME_ERR = 3;

    // CTRL bit positions
    localparam int c_CTRL_RX_IRQ_EN = 0;
    localparam int c_CTRL_TX_IRQ_EN = 1;

    // Serial frame states, shared by transmitter and receiver
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_t;

endpackage
`default_nettype wire

// File: rtl/scmp_uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : scmp_uart_rx
// Description : 8N1 serial receiver. Synchronises the asynchronous line,
//               validates the start bit at half a bit time, samples data and
//               stop bits at mid-bit, and emits a one-cycle pulse per frame.
// Ports       : clk, rst        - clock, synchronous active-high reset
//               i_ser_rx        - asynchronous serial input (idle high)
//               o_valid         - one-cycle pulse: o_data holds a good byte
//               o_data[7:0]     - received byte
//               o_frame_err     - one-cycle pulse: stop bit was low
// Revision    : 1.0  initial release
// ============================================================================
module scmp_uart_rx
    import scmp_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 1667
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_ser_rx,
    output logic       o_valid,
    output logic [7:0] o_data,
    output logic       o_frame_err
);

    localparam int                c_CW       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [c_CW-1:0]   c_BIT_LAST = c_CW'(CLKS_PER_BIT - 1);
    localparam logic [c_CW-1:0]   c_HALF     = c_CW'(CLKS_PER_BIT / 2 - 1);

    logic [1:0]      r_sync;
    logic            r_line_d;
    uart_state_t     r_state,  w_state_n;
    logic [c_CW-1:0] r_cnt,    w_cnt_n;
    logic [2:0]      r_bit,    w_bit_n;
    logic [7:0]      r_shift,  w_shift_n;
    logic            r_valid,  w_valid_n;
    logic            r_ferr,   w_ferr_n;
    logic            w_line;

    assign w_line = r_sync[1];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync   <= 2'b11;
            r_line_d <= 1'b1;
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_bit    <= '0;
            r_shift  <= '0;
            r_valid  <= 1'b0;
            r_ferr   <= 1'b0;
        end else begin
            r_sync   <= {r_sync[0], i_ser_rx};
            r_line_d <= w_line;
            r_state  <= w_state_n;
            r_cnt    <= w_cnt_n;
            r_bit    <= w_bit_n;
            r_shift  <= w_shift_n;
            r_valid  <= w_valid_n;
            r_ferr   <= w_ferr_n;
        end
    end

    always_comb begin
        w_state_n = r_state;
        w_cnt_n   = r_cnt + 1'b1;
        w_bit_n   = r_bit;
        w_shift_n = r_shift;
        w_valid_n = 1'b0;
        w_ferr_n  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_cnt_n = '0;
                // Start on a falling edge, not a low level, so a line still
                // low after a framing error does not retrigger a frame.
                if (r_line_d && !w_line) begin
                    w_state_n = ST_START;
                end
            end
            ST_START: begin
                if (r_cnt == c_HALF) begin
                    w_cnt_n   = '0;
                    w_state_n = w_line ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                // Counting restarted at mid start bit, so a full bit time
                // lands in the middle of each data bit.
                if (r_cnt == c_BIT_LAST) begin
                    w_cnt_n   = '0;
                    w_shift_n = {w_line, r_shift[7:1]};
                    w_bit_n   = r_bit + 1'b1;
                    if (r_bit == 3'd7) begin
                        w_state_n = ST_STOP;
                    end
                end
            end
            ST_STOP: begin
                if (r_cnt == c_BIT_LAST) begin
                    w_cnt_n   = '0;
                    w_state_n = ST_IDLE;
                    w_valid_n = w_line;
                    w_ferr_n  = !w_line;
                end
            end
            default: w_state_n = ST_IDLE;
        endcase
    end

    assign o_valid     = r_valid;
    assign o_data      = r_shift;
    assign o_frame_err = r_ferr;

endmodule
`default_nettype wire

// File: rtl/scmp_bus_uart.sv
`default_nettype none
// ============================================================================
// Module      : scmp_bus_uart
// Description : Memory-mapped UART for the SC/MP bus. Decodes a 4-byte window
//               (DATA, STATUS, CTRL, unused), transmits 8N1 frames, receives
//               through scmp_uart_rx and raises a registered interrupt.
// Ports       : clk, rst            - clock, synchronous active-high reset
//               ADS_n, RD_n, WR_n   - CPU strobes, active low
//               addr[11:0]          - CPU address bits 11:0
//               D_i[7:0]            - CPU data out (page in [3:0] during ADS_n)
//               D_o[7:0], hit       - read data and read-decode flag
//               ser_tx, ser_rx      - serial lines
//               irq                 - interrupt request (sense-A)
// Config      : SCMP_UART_RX_FIFO_EN - 4-entry RX FIFO instead of one holding
//               register
// Revision    : 1.0  initial release
// ============================================================================
module scmp_bus_uart
    import scmp_uart_pkg::*;
#(
    parameter logic [3:0]  BASE_PAGE    = 4'hB,
    parameter logic [11:0] BASE_OFFSET  = 12'hF00,
    parameter int          CLKS_PER_BIT = 1667
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ADS_n,
    input  logic        RD_n,
    input  logic        WR_n,
    input  logic [11:0] addr,
    input  logic [7:0]  D_i,
    output logic [7:0]  D_o,
    output logic        hit,
    output logic        ser_tx,
    input  logic        ser_rx,
    output logic        irq
);

    localparam int              c_CW       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [c_CW-1:0] c_BIT_LAST = c_CW'(CLKS_PER_BIT - 1);

    // ---------------- bus decode ----------------
    logic [3:0] r_page;
    logic       r_wr_n_d, r_rd_n_d;
    logic       w_sel, w_wr_stb, w_rd_end;
    logic [1:0] w_reg;

    assign w_sel    = (r_page == BASE_PAGE) && (addr[11:2] == BASE_OFFSET[11:2]);
    assign w_reg    = addr[1:0];
    assign w_wr_stb = w_sel && !WR_n && r_wr_n_d;   // first cycle of the write pulse
    assign w_rd_end = w_sel && RD_n && !r_rd_n_d;   // trailing edge of the read
    assign hit      = w_sel && !RD_n;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_page   <= '0;
            r_wr_n_d <= 1'b1;
            r_rd_n_d <= 1'b1;
        end else begin
            if (!ADS_n) begin
                r_page <= D_i[3:0];
            end
            r_wr_n_d <= WR_n;
            r_rd_n_d <= RD_n;
        end
    end

    // ---------------- control / status ----------------
    logic [1:0] r_ctrl;
    logic       r_overrun, r_frame_err, r_irq;
    logic       w_pop, w_status_clr, w_tx_busy, w_rx_valid;
    logic [7:0] w_rx_dout, w_status;
    logic       w_push, w_rx_ferr, w_do_pop, w_do_push, w_overflow, w_store_full;
    logic [7:0] w_rx_byte;

    assign w_pop        = w_rd_end && (w_reg == c_REG_DATA);
    assign w_status_clr = w_rd_end && (w_reg == c_REG_STATUS);

    always_comb begin
        w_status                 = 8'h00;
        w_status[c_ST_RX_VALID]  = w_rx_valid;
        w_status[c_ST_TX_BUSY]   = w_tx_busy;
        w_status[c_ST_OVERRUN]   = r_overrun;
        w_status[c_ST_FRAME_ERR] = r_frame_err;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ctrl      <= '0;
            r_overrun   <= 1'b0;
            r_frame_err <= 1'b0;
            r_irq       <= 1'b0;
        end else begin
            if (w_wr_stb && (w_reg == c_REG_CTRL)) begin
                r_ctrl <= D_i[1:0];
            end
            // A new error in the same cycle as the clearing read wins.
            if (w_overflow) begin
                r_overrun <= 1'b1;
            end else if (w_status_clr) begin
                r_overrun <= 1'b0;
            end
            if (w_rx_ferr) begin
                r_frame_err <= 1'b1;
            end else if (w_status_clr) begin
                r_frame_err <= 1'b0;
            end
            r_irq <= (r_ctrl[c_CTRL_RX_IRQ_EN] && w_rx_valid) ||
                     (r_ctrl[c_CTRL_TX_IRQ_EN] && !w_tx_busy);
        end
    end

    assign irq = r_irq;

    always_comb begin
        D_o = 8'hFF;
        if (hit) begin
            case (w_reg)
                c_REG_DATA:   D_o = w_rx_dout;
                c_REG_STATUS: D_o = w_status;
                c_REG_CTRL:   D_o = {6'b0, r_ctrl};
                default:      D_o = 8'hFF;
            endcase
        end
    end

    // ---------------- transmitter ----------------
    uart_state_t     r_tx_state, w_tx_state_n;
    logic [c_CW-1:0] r_tx_cnt,   w_tx_cnt_n;
    logic [2:0]      r_tx_bit,   w_tx_bit_n;
    logic [7:0]      r_tx_shift, w_tx_shift_n;
    logic            r_ser_tx,   w_tx_line_n;
    logic            w_tx_load;

    assign w_tx_busy = (r_tx_state != ST_IDLE);
    // Writes to DATA while a frame is in flight are silently dropped.
    assign w_tx_load = w_wr_stb && (w_reg == c_REG_DATA) && !w_tx_busy;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx_state <= ST_IDLE;
            r_tx_cnt   <= '0;
            r_tx_bit   <= '0;
            r_tx_shift <= '0;
            r_ser_tx   <= 1'b1;
        end else begin
            r_tx_state <= w_tx_state_n;
            r_tx_cnt   <= w_tx_cnt_n;
            r_tx_bit   <= w_tx_bit_n;
            r_tx_shift <= w_tx_shift_n;
            r_ser_tx   <= w_tx_line_n;
        end
    end

    always_comb begin
        w_tx_state_n = r_tx_state;
        w_tx_cnt_n   = r_tx_cnt + 1'b1;
        w_tx_bit_n   = r_tx_bit;
        w_tx_shift_n = r_tx_shift;
        case (r_tx_state)
            ST_IDLE: begin
                w_tx_cnt_n = '0;
                if (w_tx_load) begin
                    w_tx_state_n = ST_START;
                    w_tx_shift_n = D_i;
                end
            end
            ST_START: begin
                if (r_tx_cnt == c_BIT_LAST) begin
                    w_tx_cnt_n   = '0;
                    w_tx_state_n = ST_DATA;
                end
            end
            ST_DATA: begin
                if (r_tx_cnt == c_BIT_LAST) begin
                    w_tx_cnt_n   = '0;
                    w_tx_shift_n = {1'b0, r_tx_shift[7:1]};
                    w_tx_bit_n   = r_tx_bit + 1'b1;
                    if (r_tx_bit == 3'd7) begin
                        w_tx_state_n = ST_STOP;
                    end
                end
            end
            ST_STOP: begin
                if (r_tx_cnt == c_BIT_LAST) begin
                    w_tx_cnt_n   = '0;
                    w_tx_state_n = ST_IDLE;
                end
            end
            default: w_tx_state_n = ST_IDLE;
        endcase
        // Line level follows the next state so ser_tx is a clean flop output.
        case (w_tx_state_n)
            ST_START: w_tx_line_n = 1'b0;
            ST_DATA:  w_tx_line_n = w_tx_shift_n[0];
            default:  w_tx_line_n = 1'b1;
        endcase
    end

    assign ser_tx = r_ser_tx;

    // ---------------- receiver ----------------
    scmp_uart_rx #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_rx (
        .clk         (clk),
        .rst         (rst),
        .i_ser_rx    (ser_rx),
        .o_valid     (w_push),
        .o_data      (w_rx_byte),
        .o_frame_err (w_rx_ferr)
    );

    // A pop in the same cycle as a push frees a slot, so the push is kept
    // and no overrun is flagged.
    assign w_do_pop   = w_pop && w_rx_valid;
    assign w_do_push  = w_push && (!w_store_full || w_do_pop);
    assign w_overflow = w_push && w_store_full && !w_do_pop;

`ifdef SCMP_UART_RX_FIFO_EN
    logic [7:0] r_fifo [4];
    logic [1:0] r_wr_ptr, r_rd_ptr;
    logic [2:0] r_count;

    assign w_store_full = (r_count == 3'd4);
    assign w_rx_valid   = (r_count != 3'd0);
    assign w_rx_dout    = r_fifo[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_fifo[r_wr_ptr] <= w_rx_byte;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end
`else
    logic       r_rx_full;
    logic [7:0] r_rx_hold;

    assign w_store_full = r_rx_full;
    assign w_rx_valid   = r_rx_full;
    assign w_rx_dout    = r_rx_hold;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_full <= 1'b0;
            r_rx_hold <= '0;
        end else begin
            if (w_do_push) begin
                r_rx_hold <= w_rx_byte;
                r_rx_full <= 1'b1;
            end else if (w_do_pop) begin
                r_rx_full <= 1'b0;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_scmp_bus_uart.sv
`default_nettype none
// ============================================================================
// Module      : tb_scmp_bus_uart
// Description : Directed self-checking bench for scmp_bus_uart at 16 clocks
//               per bit: TX framing, RX paths, decode, reset and interrupt.
// Revision    : 1.0  initial release
// ============================================================================
module tb_scmp_bus_uart;

    localparam int c_CPB = 16;

    logic        clk    = 1'b0;
    logic        rst    = 1'b1;
    logic        ADS_n  = 1'b1;
    logic        RD_n   = 1'b1;
    logic        WR_n   = 1'b1;
    logic [11:0] addr   = '0;
    logic [7:0]  D_i    = '0;
    logic        ser_rx = 1'b1;
    logic [7:0]  D_o;
    logic        hit, ser_tx, irq;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    scmp_bus_uart #(
        .BASE_PAGE    (4'hB),
        .BASE_OFFSET  (12'hF00),
        .CLKS_PER_BIT (c_CPB)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .ADS_n  (ADS_n),
        .RD_n   (RD_n),
        .WR_n   (WR_n),
        .addr   (addr),
        .D_i    (D_i),
        .D_o    (D_o),
        .hit    (hit),
        .ser_tx (ser_tx),
        .ser_rx (ser_rx),
        .irq    (irq)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic addr_phase(input logic [3:0] pg, input logic [11:0] a);
        @(negedge clk);
        ADS_n = 1'b0; D_i = {4'h0, pg}; addr = a;
        @(negedge clk);
        ADS_n = 1'b1; D_i = 8'h00;
    endtask

    task automatic bus_write(input logic [3:0] pg, input logic [11:0] a,
                             input logic [7:0] d, input int hold);
        addr_phase(pg, a);
        WR_n = 1'b0; D_i = d;
        repeat (hold) @(negedge clk);
        WR_n = 1'b1;
    endtask

    task automatic bus_read(input logic [3:0] pg, input logic [11:0] a,
                            output logic [7:0] d, output logic h);
        addr_phase(pg, a);
        RD_n = 1'b0;
        @(negedge clk);
        d = D_o; h = hit;
        RD_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic rd_chk(input string tag, input logic [1:0] r, input logic [7:0] exp);
        logic [7:0] d;
        logic       h;
        bus_read(4'hB, {10'b1111_0000_00, r}, d, h);
        check(tag, d, exp);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        logic [9:0] frm;
        frm = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            ser_rx = frm[i];
            repeat (c_CPB) @(negedge clk);
        end
        ser_rx = 1'b1;
    endtask

    // Number of cycles ser_tx is low over a window
    task automatic count_low(input int cycles, output int lows);
        lows = 0;
        for (int i = 0; i < cycles; i++) begin
            if (ser_tx === 1'b0) lows++;
            @(negedge clk);
        end
    endtask

    logic [7:0] rd;
    logic       rh;
    int         lows;

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset state; read path usable immediately
        check("rst_ser_tx", ser_tx, 1'b1);
        check("rst_irq", irq, 1'b0);
        check("rst_hit", hit, 1'b0);
        check("rst_D_o", D_o, 8'hFF);
        rd_chk("rst_status", 2'd1, 8'h00);
        rd_chk("rst_ctrl", 2'd2, 8'h00);
        rd_chk("reg3", 2'd3, 8'hFF);

        // TX of 0x55 with STATUS.tx_busy polled throughout the frame
        bus_write(4'hB, 12'hF00, 8'h55, 1);
        fork
            begin : p_line
                logic [9:0] frm;
                int bad;
                frm = {1'b1, 8'h55, 1'b0};
                for (int b = 0; b < 10; b++) begin
                    bad = 0;
                    for (int c = 0; c < c_CPB; c++) begin
                        if (ser_tx !== frm[b]) bad++;
                        @(negedge clk);
                    end
                    check($sformatf("tx_bit%0d_bad_cycles", b), bad, 0);
                end
            end
            begin : p_busy
                logic [7:0] d;
                logic h;
                int notbusy;
                notbusy = 0;
                for (int k = 0; k < 30; k++) begin
                    bus_read(4'hB, 12'hF01, d, h);
                    if (d[1] !== 1'b1) notbusy++;
                end
                check("tx_busy_polls_low", notbusy, 0);
            end
        join
        check("tx_idle_line", ser_tx, 1'b1);
        rd_chk("tx_done_status", 2'd1, 8'h00);

        // RX single byte
        send_frame(8'hA3, 1'b1);
        rd_chk("rx_status", 2'd1, 8'h01);
        rd_chk("rx_data", 2'd0, 8'hA3);
        rd_chk("rx_status_after_pop", 2'd1, 8'h00);

        // Two frames without an intervening read
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
`ifdef SCMP_UART_RX_FIFO_EN
        rd_chk("fifo_status", 2'd1, 8'h01);
        rd_chk("fifo_data0", 2'd0, 8'h11);
        rd_chk("fifo_data1", 2'd0, 8'h22);
`else
        rd_chk("ovr_status", 2'd1, 8'h05);
        rd_chk("ovr_data_first", 2'd0, 8'h11);
`endif
        rd_chk("two_frames_status_clear", 2'd1, 8'h00);

        // Framing error, then a short glitch
        send_frame(8'h5A, 1'b0);
        repeat (4) @(negedge clk);
        rd_chk("ferr_status", 2'd1, 8'h08);
        rd_chk("ferr_status_cleared", 2'd1, 8'h00);
        ser_rx = 1'b0;
        repeat (4) @(negedge clk);
        ser_rx = 1'b1;
        repeat (200) @(negedge clk);
        rd_chk("glitch_status", 2'd1, 8'h00);

        // Off-window accesses
        bus_write(4'hA, 12'hF00, 8'h77, 1);
        count_low(60, lows);
        check("pageA_write_no_tx", lows, 0);
        bus_write(4'hA, 12'hF02, 8'h03, 1);
        rd_chk("pageA_ctrl_untouched", 2'd2, 8'h00);
        bus_read(4'hA, 12'hF00, rd, rh);
        check("pageA_hit", rh, 1'b0);
        check("pageA_D_o", rd, 8'hFF);
        bus_read(4'hB, 12'hF04, rd, rh);
        check("F04_hit", rh, 1'b0);
        check("F04_D_o", rd, 8'hFF);
        bus_write(4'hB, 12'hF04, 8'h77, 1);
        count_low(60, lows);
        check("F04_write_no_tx", lows, 0);

        // Long write strobe: exactly one frame of 0x0F (start + four zeros)
        fork
            bus_write(4'hB, 12'hF00, 8'h0F, 3);
            count_low(400, lows);
        join
        check("long_wr_low_cycles", lows, 5 * c_CPB);

        // Reset in the middle of data bit 3
        bus_write(4'hB, 12'hF00, 8'h55, 1);
        repeat (c_CPB + 3 * c_CPB + 8) @(negedge clk);
        check("mid_bit3_level", ser_tx, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        check("rst_abort_ser_tx", ser_tx, 1'b1);
        rst = 1'b0;
        count_low(200, lows);
        check("rst_abort_no_resume", lows, 0);
        rd_chk("rst_abort_status", 2'd1, 8'h00);

        // RX interrupt
        bus_write(4'hB, 12'hF02, 8'h01, 1);
        rd_chk("ctrl_rx_en", 2'd2, 8'h01);
        check("irq_idle", irq, 1'b0);
        send_frame(8'h3C, 1'b1);
        check("irq_rx_set", irq, 1'b1);
        rd_chk("irq_status", 2'd1, 8'h01);
        check("irq_held", irq, 1'b1);
        rd_chk("irq_data", 2'd0, 8'h3C);
        @(negedge clk);
        check("irq_cleared", irq, 1'b0);

        // TX interrupt and CTRL masking
        bus_write(4'hB, 12'hF02, 8'hFF, 1);
        rd_chk("ctrl_mask", 2'd2, 8'h03);
        check("irq_tx_idle", irq, 1'b1);
        bus_write(4'hB, 12'hF00, 8'h01, 1);
        repeat (3) @(negedge clk);
        check("irq_tx_busy", irq, 1'b0);
        repeat (10 * c_CPB) @(negedge clk);
        check("irq_tx_done", irq, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
